alu_seq_unit: RTL and testbench

ALU_SEQ_UNIT -- requirements
Module: alu_seq_unit

---
 rtl/alu_seq_unit.sv | 183 ++++++++++++++++++
 tb/tb_alu_seq_unit.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_unit.sv
// alu_seq_unit: sequential ALU with a one-shot handshake interface.
// Single-cycle ops (ADD/AND/SLT/SUB/OR/XOR/NOR) finish on the accept edge.
// MULT runs a 32-step unsigned shift-add, one multiplier bit per cycle.
// Optional feature macro: ALU_SEQ_MULT_HI_EN adds the res_hi port that
// carries product bits [63:32] and widens the accumulator to 64 bits.
module alu_seq_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        s0,
    input  logic        s1,
    input  logic        s2,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] res
`ifdef ALU_SEQ_MULT_HI_EN
    ,
    output logic [31:0] res_hi
`endif
);

`ifdef ALU_SEQ_MULT_HI_EN
    localparam int PW = 64;
`else
    localparam int PW = 32;
`endif

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_AND  = 3'b001;
    localparam logic [2:0] OP_MULT = 3'b010;
    localparam logic [2:0] OP_SLT  = 3'b011;
    localparam logic [2:0] OP_SUB  = 3'b100;
    localparam logic [2:0] OP_OR   = 3'b101;
    localparam logic [2:0] OP_XOR  = 3'b110;
    localparam logic [2:0] OP_NOR  = 3'b111;

    localparam logic [5:0] MUL_STEPS = 6'd32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   mcand_q, mcand_d;
    logic [31:0]     mplier_q, mplier_d;
    logic [PW-1:0]   acc_q, acc_d;
    logic [5:0]      cnt_q, cnt_d;
    logic [31:0]     res_q, res_d;
`ifdef ALU_SEQ_MULT_HI_EN
    logic [31:0]     res_hi_q, res_hi_d;
`endif

    logic [2:0]      op;
    logic [31:0]     alu_res;
    logic            accept;

    assign op     = {s2, s1, s0};
    assign accept = (state_q == IDLE) && in_valid;

    // Single-cycle result computed straight from the inputs on the accept edge
    always_comb begin
        alu_res = 32'h0;
        case (op)
            OP_ADD:  alu_res = a + b;
            OP_AND:  alu_res = a & b;
            OP_SLT:  alu_res = ($signed(a) < $signed(b)) ? 32'h1 : 32'h0;
            OP_SUB:  alu_res = a - b;
            OP_OR:   alu_res = a | b;
            OP_XOR:  alu_res = a ^ b;
            OP_NOR:  alu_res = ~(a | b);
            default: alu_res = 32'h0;
        endcase
    end

    // FSM next state and handshake outputs
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = (op == OP_MULT) ? MUL : DONE;
                end
            end
            MUL: begin
                // The extra cycle at cnt_q == 32 moves the product into res.
                if (cnt_q == MUL_STEPS) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath next state: operand capture, shift-add steps, result load
    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        res_d    = res_q;
`ifdef ALU_SEQ_MULT_HI_EN
        res_hi_d = res_hi_q;
`endif
        if (accept) begin
            mcand_d  = PW'(a);
            mplier_d = b;
            acc_d    = '0;
            cnt_d    = 6'd0;
            if (op != OP_MULT) begin
                res_d = alu_res;
`ifdef ALU_SEQ_MULT_HI_EN
                res_hi_d = 32'h0;
`endif
            end
        end else if (state_q == MUL) begin
            if (cnt_q == MUL_STEPS) begin
                res_d = acc_q[31:0];
`ifdef ALU_SEQ_MULT_HI_EN
                res_hi_d = acc_q[63:32];
`endif
            end else begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 6'd1;
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers; reset discards any pending result
    always_ff @(posedge clk) begin
        if (reset) begin
            mcand_q  <= '0;
            mplier_q <= 32'h0;
            acc_q    <= '0;
            cnt_q    <= 6'd0;
            res_q    <= 32'h0;
`ifdef ALU_SEQ_MULT_HI_EN
            res_hi_q <= 32'h0;
`endif
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            res_q    <= res_d;
`ifdef ALU_SEQ_MULT_HI_EN
            res_hi_q <= res_hi_d;
`endif
        end
    end

    assign res = res_q;
`ifdef ALU_SEQ_MULT_HI_EN
    assign res_hi = res_hi_q;
`endif

endmodule

// File: tb/tb_alu_seq_unit.sv
// tb_alu_seq_unit: directed table, corner sequences and random ops for
// alu_seq_unit, checked against a plain-arithmetic reference model.
module tb_alu_seq_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        s0, s1, s2;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] res;
`ifdef ALU_SEQ_MULT_HI_EN
    logic [31:0] res_hi;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_seq_unit dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .s0        (s0),
        .s1        (s1),
        .s2        (s2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res       (res)
`ifdef ALU_SEQ_MULT_HI_EN
        ,
        .res_hi    (res_hi)
`endif
    );

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          hold;
        logic [31:0] exp_lo;
        logic [31:0] exp_hi;
    } vec_t;

    vec_t tbl [14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Reference: result straight from the op definitions, {hi, lo}
    function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
        longint unsigned ux, uy;
        int sx, sy;
        ux = longint'(x);
        uy = longint'(y);
        sx = int'(x);
        sy = int'(y);
        case (op)
            3'd0:    model = {32'h0, 32'(ux + uy)};
            3'd1:    model = {32'h0, x & y};
            3'd2:    model = 64'(ux * uy);
            3'd3:    model = (sx < sy) ? 64'h1 : 64'h0;
            3'd4:    model = {32'h0, 32'(ux - uy)};
            3'd5:    model = {32'h0, x | y};
            3'd6:    model = {32'h0, x ^ y};
            default: model = {32'h0, ~(x | y)};
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble_inputs();
        in_valid = 1'($urandom_range(0, 1));
        a = $urandom;
        b = $urandom;
        {s2, s1, s0} = 3'($urandom);
    endtask

    task automatic check_hi(input string name, input logic [31:0] exp);
`ifdef ALU_SEQ_MULT_HI_EN
        check(name, res_hi, exp);
`else
        if (exp === 32'hx) $display("note %s", name);
`endif
    endtask

    // One full transaction: accept, wait for result, hold, handshake
    task automatic run_op(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                          input int hold, input logic [31:0] exp_lo, input logic [31:0] exp_hi,
                          input string tag);
        int lat;
        check({tag, " in_ready idle"}, {31'h0, in_ready}, 32'h1);
        {s2, s1, s0} = op;
        a = x;
        b = y;
        in_valid = 1'b1;
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        check({tag, " in_ready busy"}, {31'h0, in_ready}, 32'h0);
        lat = 0;
        while (!out_valid && lat < 60) begin
            scramble_inputs();
            tick();
            lat++;
        end
        in_valid = 1'b0;
        check({tag, " latency"}, 32'(lat), (op == 3'd2) ? 32'd33 : 32'd0);
        check({tag, " res"}, res, exp_lo);
        check_hi({tag, " res_hi"}, exp_hi);
        for (int k = 0; k < hold; k++) begin
            out_ready = 1'b0;
            scramble_inputs();
            tick();
            check({tag, " hold out_valid"}, {31'h0, out_valid}, 32'h1);
            check({tag, " hold in_ready"}, {31'h0, in_ready}, 32'h0);
            check({tag, " hold res"}, res, exp_lo);
            check_hi({tag, " hold res_hi"}, exp_hi);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, " post out_valid"}, {31'h0, out_valid}, 32'h0);
        check({tag, " post in_ready"}, {31'h0, in_ready}, 32'h1);
        $display("txn %s op=%0d a=%08h b=%08h res=%08h exp=%08h_%08h lat=%0d hold=%0d",
                 tag, op, x, y, res, exp_hi, exp_lo, lat, hold);
    endtask

    initial begin
        int seen;
        logic [2:0]  rop;
        logic [31:0] rx, ry;
        logic [63:0] e;

        tbl[0]  = '{3'd0, 32'hFFFF0000, 32'h0000BBBB, 0, 32'hFFFFBBBB, 32'h0};
        tbl[1]  = '{3'd4, 32'hFFFFFFFF, 32'h01010011, 1, 32'hFEFEFFEE, 32'h0};
        tbl[2]  = '{3'd7, 32'h0000F0F0, 32'hFFFF0000, 0, 32'h00000F0F, 32'h0};
        tbl[3]  = '{3'd3, 32'hFFFF0000, 32'hAAAA1111, 0, 32'h00000000, 32'h0};
        tbl[4]  = '{3'd3, 32'h0000CCCC, 32'h1111DDDD, 0, 32'h00000001, 32'h0};
        tbl[5]  = '{3'd2, 32'h00010001, 32'h00010001, 0, 32'h00020001, 32'h00000001};
        tbl[6]  = '{3'd0, 32'h12345678, 32'h11111111, 5, 32'h23456789, 32'h0};
        tbl[7]  = '{3'd1, 32'h12345678, 32'h0F0F0F0F, 0, 32'h02040608, 32'h0};
        tbl[8]  = '{3'd5, 32'hF0F00000, 32'h0000000F, 0, 32'hF0F0000F, 32'h0};
        tbl[9]  = '{3'd6, 32'hFFFF0000, 32'h0F0F0F0F, 2, 32'hF0F00F0F, 32'h0};
        tbl[10] = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 32'h00000001, 32'hFFFFFFFE};
        tbl[11] = '{3'd2, 32'h00000000, 32'hDEADBEEF, 0, 32'h00000000, 32'h00000000};
        tbl[12] = '{3'd0, 32'hFFFFFFFF, 32'h00000001, 0, 32'h00000000, 32'h0};
        tbl[13] = '{3'd3, 32'h80000000, 32'h7FFFFFFF, 0, 32'h00000001, 32'h0};

        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = 32'h0;
        b = 32'h0;
        {s2, s1, s0} = 3'd0;
        tick();
        tick();
        check("reset in_ready", {31'h0, in_ready}, 32'h1);
        check("reset out_valid", {31'h0, out_valid}, 32'h0);
        check("reset res", res, 32'h0);
        check_hi("reset res_hi", 32'h0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 14; i++) begin
            run_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].hold, tbl[i].exp_lo, tbl[i].exp_hi,
                   $sformatf("vec%0d", i));
        end

        // Reset on the 10th MUL cycle aborts the multiply
        {s2, s1, s0} = 3'd2;
        a = 32'h00010001;
        b = 32'h00010001;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (9) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort in_ready", {31'h0, in_ready}, 32'h1);
        check("abort out_valid", {31'h0, out_valid}, 32'h0);
        check("abort res", res, 32'h0);
        check_hi("abort res_hi", 32'h0);
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (out_valid) seen++;
        end
        check("abort no result", 32'(seen), 32'd0);
        $display("txn abort mult reset on MUL cycle 10");
        run_op(3'd1, 32'hFFFFFFFF, 32'h00000000, 0, 32'h00000000, 32'h0, "abort_and");

        // Reset wins over in_valid and out_ready in DONE
        {s2, s1, s0} = 3'd0;
        a = 32'h00000005;
        b = 32'h00000007;
        in_valid = 1'b1;
        tick();
        check("prio done", {31'h0, out_valid}, 32'h1);
        out_ready = 1'b1;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        out_ready = 1'b0;
        in_valid = 1'b0;
        check("prio res", res, 32'h0);
        check("prio out_valid", {31'h0, out_valid}, 32'h0);
        check("prio in_ready", {31'h0, in_ready}, 32'h1);
        tick();
        check("prio stay idle", {31'h0, out_valid}, 32'h0);
        $display("txn prio reset over in_valid/out_ready");

        // Random ops against the reference model
        for (int i = 0; i < 40; i++) begin
            rop = 3'($urandom_range(0, 7));
            rx = $urandom;
            ry = $urandom;
            case ($urandom_range(0, 5))
                0: rx = 32'h0;
                1: ry = 32'hFFFFFFFF;
                default: ;
            endcase
            e = model(rop, rx, ry);
            run_op(rop, rx, ry, $urandom_range(0, 3), e[31:0], e[63:32], $sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
